// File: rtl/tsense_pkg.sv
// Shared types and switch patterns for the temperature sensor phase sequencer.
package tsense_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRECHARGE,
    S_BLANK_D,
    S_DIODE,
    S_BLANK_B,
    S_BIGDIODE,
    S_CHARGE,
    S_DONE
  } state_t;

  // Bit positions of the charge-transfer switches inside p_chg.
  localparam int PA = 0;
  localparam int PB = 1;
  localparam int PC = 2;
  localparam int PD = 3;

  localparam logic [3:0] PRE_PAT = 4'((1 << PB) | (1 << PC) | (1 << PD));
  localparam logic [3:0] H_PAT   = 4'((1 << PA) | (1 << PB));
  localparam logic [3:0] L_PAT   = 4'((1 << PA) | (1 << PC));

  // Charge-transfer pattern selected by the comparator decision.
  function automatic logic [3:0] chg_pat(input logic i_high);
    return i_high ? H_PAT : L_PAT;
  endfunction

endpackage

// File: rtl/tsense_seq_if.sv
// Request / result handshake between the sequencer and its consumer.
interface tsense_seq_if #(
  parameter int CODE_W = 5
);
  logic              start;
  logic              busy;
  logic [CODE_W-1:0] code;
  logic              valid;
  logic              ready;

  // Consumer side: requests conversions and accepts codes.
  modport master (
    output start,
    output ready,
    input  busy,
    input  code,
    input  valid
  );

  // Sequencer side.
  modport slave (
    input  start,
    input  ready,
    output busy,
    output code,
    output valid
  );
endinterface

// File: rtl/tsense_phase_timer.sv
// Down-counter shared by all timed phases. Load with (length - 1); o_last
// marks the final cycle of the phase, o_penult the cycle before it.
module tsense_phase_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_last,
  output logic             o_penult
);

  logic [CNT_W-1:0] r_cnt;

  // Load on strobe, otherwise count down and hold at terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_last   = (r_cnt == '0);
  assign o_penult = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/tsense_seq.sv
// Phase sequencer and result accumulator for the switched-capacitor
// temperature sensor front end.
//
//   state       | meaning
//   ------------+-----------------------------------------------
//   IDLE        | waiting for start
//   PRECHARGE   | precharge caps, PRE_CYC cycles
//   BLANK_D     | one dead cycle before the diode phase
//   DIODE       | diode current phase, DIODE_CYC cycles
//   BLANK_B     | one dead cycle before the big-diode phase
//   BIGDIODE    | big-diode phase, comparator sampled in last cycle
//   CHARGE      | charge transfer (H or L pattern), CHG_CYC cycles
//   DONE        | result presented, waiting for ready
//
// Outputs are registered with the value they must carry in the state being
// entered, so every switch change lines up with the state change.
module tsense_seq
  import tsense_pkg::*;
#(
  parameter int PRE_CYC   = 15,
  parameter int DIODE_CYC = 8,
  parameter int CHG_CYC   = 6,
  parameter int NSAMP     = 16,
  parameter int CONT      = 0,
  parameter int CNT_W     = 6,
  parameter int CODE_W    = $clog2(NSAMP + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_cmp,
  output logic       o_pre_chrg,
  output logic [1:0] o_p_diode,
  output logic [1:0] o_p_big,
  output logic [3:0] o_p_chg,
  output logic       o_s_bg2cmp,
  output logic       o_src_n,
  output logic       o_snk,
  output logic       o_cmp_p1,
  output logic       o_cmp_p2,
  tsense_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] PRE_LD = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] DIO_LD = CNT_W'(DIODE_CYC - 1);
  localparam logic [CNT_W-1:0] CHG_LD = CNT_W'(CHG_CYC - 1);

  state_t            r_state;
  logic              r_pre_chrg;
  logic [1:0]        r_p_diode;
  logic [1:0]        r_p_big;
  logic [3:0]        r_p_chg;
  logic              r_s_bg2cmp;
  logic              r_src_n;
  logic              r_snk;
  logic              r_cmp_p1;
  logic              r_cmp_p2;
  logic              r_busy;
  logic              r_valid;
  logic [CODE_W-1:0] r_code;
  logic [CODE_W-1:0] r_ones;
  logic [CODE_W-1:0] r_iter;

  logic              w_last;
  logic              w_penult;
  logic              w_load;
  logic [CNT_W-1:0]  w_load_val;

  // Timer preload: untimed states keep the next phase length loaded so the
  // count is correct from the first cycle of the following timed phase.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_load     = 1'b1;
        w_load_val = PRE_LD;
      end
      S_BLANK_D, S_BLANK_B: begin
        w_load     = 1'b1;
        w_load_val = DIO_LD;
      end
      S_BIGDIODE: begin
        w_load     = w_last;
        w_load_val = CHG_LD;
      end
      default: ;
    endcase
  end

  tsense_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_last     (w_last),
    .o_penult   (w_penult)
  );

  // Sequencer state, counters and all registered switch / handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pre_chrg <= 1'b0;
      r_p_diode  <= 2'b00;
      r_p_big    <= 2'b00;
      r_p_chg    <= 4'b0000;
      r_s_bg2cmp <= 1'b0;
      r_src_n    <= 1'b0;
      r_snk      <= 1'b0;
      r_cmp_p1   <= 1'b1;
      r_cmp_p2   <= 1'b0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_code     <= '0;
      r_ones     <= '0;
      r_iter     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_PRECHARGE;
            r_ones     <= '0;
            r_iter     <= '0;
            r_busy     <= 1'b1;
            r_pre_chrg <= 1'b1;
            r_p_chg    <= PRE_PAT;
            r_s_bg2cmp <= 1'b1;
          end
        end
        S_PRECHARGE: begin
          if (w_last) begin
            r_state    <= S_BLANK_D;
            r_pre_chrg <= 1'b0;
            r_p_chg    <= 4'b0000;
            r_s_bg2cmp <= 1'b0;
          end
        end
        S_BLANK_D: begin
          r_state   <= S_DIODE;
          r_p_diode <= 2'b01;
        end
        S_DIODE: begin
          if (w_last) begin
            r_state   <= S_BLANK_B;
            r_p_diode <= 2'b00;
          end else begin
            // Phase 2 overlaps phase 1 but is trimmed off the first and last cycle.
            r_p_diode[1] <= ~w_penult;
          end
        end
        S_BLANK_B: begin
          r_state <= S_BIGDIODE;
          r_p_big <= 2'b01;
          r_src_n <= i_cmp;
          r_snk   <= ~i_cmp;
        end
        S_BIGDIODE: begin
          if (w_last) begin
            r_state    <= S_CHARGE;
            r_p_big    <= 2'b00;
            r_src_n    <= 1'b0;
            r_snk      <= 1'b0;
            r_p_chg    <= chg_pat(i_cmp);
            r_s_bg2cmp <= 1'b1;
            if (i_cmp && (r_ones != CODE_W'(NSAMP))) begin
              r_ones <= r_ones + 1'b1;
            end
          end else begin
            r_p_big[1] <= ~w_penult;
            r_src_n    <= i_cmp;
            r_snk      <= ~i_cmp;
          end
        end
        S_CHARGE: begin
          if (w_last) begin
            r_p_chg    <= 4'b0000;
            r_s_bg2cmp <= 1'b0;
            r_cmp_p1   <= ~r_cmp_p1;
            r_cmp_p2   <= ~r_cmp_p2;
            r_iter     <= r_iter + 1'b1;
            if (r_iter == CODE_W'(NSAMP - 1)) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_BLANK_D;
            end
          end
        end
        S_DONE: begin
          if (!r_valid) begin
            r_valid <= 1'b1;
            r_code  <= r_ones;
          end else if (bus.ready) begin
            r_valid <= 1'b0;
            if (CONT != 0) begin
              r_state    <= S_PRECHARGE;
              r_ones     <= '0;
              r_iter     <= '0;
              r_pre_chrg <= 1'b1;
              r_p_chg    <= PRE_PAT;
              r_s_bg2cmp <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_pre_chrg = r_pre_chrg;
  assign o_p_diode  = r_p_diode;
  assign o_p_big    = r_p_big;
  assign o_p_chg    = r_p_chg;
  assign o_s_bg2cmp = r_s_bg2cmp;
  assign o_src_n    = r_src_n;
  assign o_snk      = r_snk;
  assign o_cmp_p1   = r_cmp_p1;
  assign o_cmp_p2   = r_cmp_p2;
  assign bus.busy   = r_busy;
  assign bus.valid  = r_valid;
  assign bus.code   = r_code;

endmodule
